// File: rtl/or1200_ifetch_resp.sv
// or1200_ifetch_resp: instruction-fetch responder between the IF stage and a
// Wishbone classic instruction bus, used when no instruction cache is built.
module or1200_ifetch_resp #(
    parameter int TIMEOUT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] icpu_adr_i,
    input  logic        icpu_cycstb_i,
    output logic [31:0] icpu_dat_o,
    output logic        icpu_ack_o,
    output logic        icpu_err_o,
    output logic [31:0] icpu_adr_o,
    output logic [3:0]  icpu_tag_o,
    output logic [31:0] iwb_adr_o,
    output logic        iwb_cyc_o,
    output logic        iwb_stb_o,
    output logic        iwb_we_o,
    output logic [3:0]  iwb_sel_o,
    output logic [2:0]  iwb_cti_o,
    input  logic [31:0] iwb_dat_i,
    input  logic        iwb_ack_i,
    input  logic        iwb_err_i,
    input  logic        iwb_rty_i
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0] ITAG_NONE = 4'h0;
    localparam logic [3:0] ITAG_NI   = 4'h1;
    localparam logic [3:0] ITAG_BE   = 4'hb;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RETRY,
        ABORT
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 cyc_q, cyc_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic [31:0]          dat_q, dat_d;
    logic [31:0]          radr_q, radr_d;
    logic [3:0]           tag_q, tag_d;

    logic [TIMEOUT_W-1:0] cnt_inc;
    logic                 stale;
    logic                 timeout;
    logic                 bus_term;
    logic                 unused_adr_lsb;

    assign unused_adr_lsb = ^icpu_adr_i[1:0];

    // A fetch is stale once the PC generator stops asking for this word.
    assign stale = !icpu_cycstb_i || (icpu_adr_i[31:2] != addr_q[31:2]);

    // Saturating, so a retry taken on the last allowed cycle still times out.
    assign cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    assign timeout  = (cnt_inc == CNT_MAX);
    assign bus_term = iwb_err_i | iwb_ack_i | iwb_rty_i | timeout;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = 32'h0;
        tag_d   = ITAG_NONE;
        radr_d  = radr_q;

        unique case (state_q)
            IDLE: begin
                if (icpu_cycstb_i) begin
                    addr_d  = {icpu_adr_i[31:2], 2'b00};
                    cnt_d   = '0;
                    cyc_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_inc;
                if (stale) begin
                    if (bus_term) begin
                        cyc_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = ABORT;
                    end
                end else if (iwb_err_i) begin
                    err_d   = 1'b1;
                    tag_d   = ITAG_BE;
                    radr_d  = addr_q;
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end else if (iwb_ack_i) begin
                    ack_d   = 1'b1;
                    dat_d   = iwb_dat_i;
                    tag_d   = ITAG_NI;
                    radr_d  = addr_q;
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end else if (iwb_rty_i) begin
                    cyc_d   = 1'b0;
                    state_d = RETRY;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    tag_d   = ITAG_BE;
                    radr_d  = addr_q;
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            RETRY: begin
                if (stale) begin
                    state_d = IDLE;
                end else begin
                    cyc_d   = 1'b1;
                    state_d = REQ;
                end
            end
            ABORT: begin
                // Bus cycle must finish cleanly; its result is thrown away.
                cnt_d = cnt_inc;
                if (bus_term) begin
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= 32'h0;
            radr_q  <= 32'h0;
            tag_q   <= ITAG_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            radr_q  <= radr_d;
            tag_q   <= tag_d;
        end
    end

    assign icpu_dat_o = dat_q;
    assign icpu_ack_o = ack_q;
    assign icpu_err_o = err_q;
    assign icpu_adr_o = radr_q;
    assign icpu_tag_o = tag_q;

    assign iwb_adr_o  = addr_q;
    assign iwb_cyc_o  = cyc_q;
    assign iwb_stb_o  = cyc_q;
    assign iwb_we_o   = 1'b0;
    assign iwb_sel_o  = 4'hf;
    assign iwb_cti_o  = 3'b000;

endmodule

// File: tb/tb_or1200_ifetch_resp.sv
// tb_or1200_ifetch_resp: directed fetch scenarios plus randomized traffic,
// all checked every cycle against a transaction-level fetch model.
module tb_or1200_ifetch_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] icpu_adr_i = 32'h0;
    logic        icpu_cycstb_i = 1'b0;
    logic [31:0] icpu_dat_o;
    logic        icpu_ack_o;
    logic        icpu_err_o;
    logic [31:0] icpu_adr_o;
    logic [3:0]  icpu_tag_o;
    logic [31:0] iwb_adr_o;
    logic        iwb_cyc_o;
    logic        iwb_stb_o;
    logic        iwb_we_o;
    logic [3:0]  iwb_sel_o;
    logic [2:0]  iwb_cti_o;
    logic [31:0] iwb_dat_i = 32'h0;
    logic        iwb_ack_i = 1'b0;
    logic        iwb_err_i = 1'b0;
    logic        iwb_rty_i = 1'b0;

    always #5 clk = ~clk;

    or1200_ifetch_resp #(.TIMEOUT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .icpu_adr_i   (icpu_adr_i),
        .icpu_cycstb_i(icpu_cycstb_i),
        .icpu_dat_o   (icpu_dat_o),
        .icpu_ack_o   (icpu_ack_o),
        .icpu_err_o   (icpu_err_o),
        .icpu_adr_o   (icpu_adr_o),
        .icpu_tag_o   (icpu_tag_o),
        .iwb_adr_o    (iwb_adr_o),
        .iwb_cyc_o    (iwb_cyc_o),
        .iwb_stb_o    (iwb_stb_o),
        .iwb_we_o     (iwb_we_o),
        .iwb_sel_o    (iwb_sel_o),
        .iwb_cti_o    (iwb_cti_o),
        .iwb_dat_i    (iwb_dat_i),
        .iwb_ack_i    (iwb_ack_i),
        .iwb_err_i    (iwb_err_i),
        .iwb_rty_i    (iwb_rty_i)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic check4(input string name, input logic [3:0] act,
                          input logic [3:0] exp);
        check32(name, {28'b0, act}, {28'b0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch model: a fetch owns the bus until terminated; it counts bus
    // cycles spent with cyc high, and a cancelled fetch keeps the bus
    // until the slave (or the 15-cycle limit) ends it, silently.
    logic        m_cyc, m_gap, m_live;
    logic [31:0] m_addr;
    int          m_n;
    logic        e_ack, e_err;
    logic [31:0] e_dat, e_radr;
    logic [3:0]  e_tag;

    task automatic model_step();
        logic stale, to, term;
        e_ack = 1'b0;
        e_err = 1'b0;
        e_dat = 32'h0;
        e_tag = 4'h0;
        stale = !icpu_cycstb_i || (icpu_adr_i[31:2] != m_addr[31:2]);
        if (m_gap) begin
            m_gap = 1'b0;
            m_cyc = !stale;
        end else if (!m_cyc) begin
            if (icpu_cycstb_i) begin
                m_addr = {icpu_adr_i[31:2], 2'b00};
                m_n    = 0;
                m_cyc  = 1'b1;
                m_live = 1'b1;
            end
        end else begin
            m_n++;
            to   = (m_n >= 15);
            term = iwb_err_i || iwb_ack_i || iwb_rty_i || to;
            if (!m_live) begin
                if (term) m_cyc = 1'b0;
            end else if (stale) begin
                if (term) m_cyc = 1'b0;
                else m_live = 1'b0;
            end else if (iwb_err_i || (!iwb_ack_i && !iwb_rty_i && to)) begin
                m_cyc  = 1'b0;
                e_err  = 1'b1;
                e_tag  = 4'hb;
                e_radr = m_addr;
            end else if (iwb_ack_i) begin
                m_cyc  = 1'b0;
                e_ack  = 1'b1;
                e_dat  = iwb_dat_i;
                e_tag  = 4'h1;
                e_radr = m_addr;
            end else if (iwb_rty_i) begin
                m_cyc = 1'b0;
                m_gap = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cyc  = 1'b0;
            m_gap  = 1'b0;
            m_live = 1'b0;
            m_addr = 32'h0;
            m_n    = 0;
            e_ack  = 1'b0;
            e_err  = 1'b0;
            e_dat  = 32'h0;
            e_radr = 32'h0;
            e_tag  = 4'h0;
        end else begin
            model_step();
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin : cmp
        logic [111:0] act, exp;
        if (chk_en) begin
            act = {iwb_cyc_o, iwb_stb_o, iwb_we_o, iwb_sel_o, iwb_cti_o,
                   icpu_ack_o, icpu_err_o, icpu_tag_o, icpu_dat_o,
                   icpu_adr_o, iwb_adr_o};
            exp = {m_cyc, m_cyc, 1'b0, 4'hf, 3'b000, e_ack, e_err, e_tag,
                   e_dat, e_radr, m_addr};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL model t=%0t: got %h, expected %h",
                         $time, act, exp);
            end
        end
    end

    // Slave: 0 ack after s_wait, 1 err+ack after s_wait, 2 silent,
    // 3 one rty at s_rty_at then silent, 4 random.
    int          s_mode = 2;
    int          s_wait = 0;
    int          s_rty_at = 0;
    logic [31:0] s_dat = 32'h0;
    bit          rty_done = 1'b0;

    always @(posedge clk) begin : slave
        int  wcnt;
        int  r;
        bit  silent;
        #2;
        iwb_ack_i = 1'b0;
        iwb_err_i = 1'b0;
        iwb_rty_i = 1'b0;
        iwb_dat_i = $urandom;
        if (iwb_cyc_o) begin
            case (s_mode)
                0: if (wcnt == s_wait) begin
                    iwb_ack_i = 1'b1;
                    iwb_dat_i = s_dat;
                end
                1: if (wcnt == s_wait) begin
                    iwb_ack_i = 1'b1;
                    iwb_err_i = 1'b1;
                end
                2: ;
                3: if (!rty_done && wcnt == s_rty_at) begin
                    iwb_rty_i = 1'b1;
                    rty_done = 1'b1;
                end
                default: begin
                    if (wcnt == 0) silent = ($urandom_range(0, 11) == 0);
                    if (!silent) begin
                        r = $urandom_range(0, 99);
                        iwb_ack_i = (r < 30);
                        iwb_err_i = (r >= 25 && r < 30) || (r >= 90 && r < 94);
                        iwb_rty_i = (r >= 80 && r < 88);
                    end
                end
            endcase
            wcnt++;
        end else begin
            wcnt = 0;
        end
    end

    initial begin
        int  ncyc, nlow, npulse;
        bit  got;

        chk_en = 1'b1;
        #1 rst = 1'b0;
        #2;
        check1("rst cyc", iwb_cyc_o, 1'b0);
        check1("rst stb", iwb_stb_o, 1'b0);
        check1("rst ack", icpu_ack_o, 1'b0);
        check1("rst err", icpu_err_o, 1'b0);
        check32("rst dat", icpu_dat_o, 32'h0);
        check32("rst icpu_adr", icpu_adr_o, 32'h0);
        check32("rst iwb_adr", iwb_adr_o, 32'h0);
        check4("rst tag", icpu_tag_o, 4'h0);
        #9 rst = 1'b1;

        // Zero-wait read.
        s_mode = 0;
        s_wait = 0;
        s_dat  = 32'h1500_0000;
        tick();
        icpu_adr_i    = 32'h0000_0104;
        icpu_cycstb_i = 1'b1;
        tick();
        check1("zw cyc", iwb_cyc_o, 1'b1);
        check32("zw iwb_adr", iwb_adr_o, 32'h0000_0104);
        check1("zw early ack", icpu_ack_o, 1'b0);
        tick();
        check1("zw ack", icpu_ack_o, 1'b1);
        check1("zw err", icpu_err_o, 1'b0);
        check32("zw dat", icpu_dat_o, 32'h1500_0000);
        check4("zw tag", icpu_tag_o, 4'h1);
        check32("zw icpu_adr", icpu_adr_o, 32'h0000_0104);
        icpu_cycstb_i = 1'b0;
        tick();
        check1("zw ack drop", icpu_ack_o, 1'b0);
        check32("zw dat clr", icpu_dat_o, 32'h0);
        check32("zw adr hold", icpu_adr_o, 32'h0000_0104);

        // Three wait states, unaligned address.
        s_wait = 3;
        s_dat  = 32'ha5a5_0001;
        icpu_adr_i    = 32'h0000_0203;
        icpu_cycstb_i = 1'b1;
        tick();
        check32("ws iwb_adr", iwb_adr_o, 32'h0000_0200);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check1("ws no ack", icpu_ack_o, 1'b0);
            check1("ws cyc", iwb_cyc_o, 1'b1);
        end
        tick();
        check1("ws ack", icpu_ack_o, 1'b1);
        check32("ws dat", icpu_dat_o, 32'ha5a5_0001);
        check32("ws icpu_adr", icpu_adr_o, 32'h0000_0200);
        icpu_cycstb_i = 1'b0;
        tick();

        // Error and ack together.
        s_mode = 1;
        s_wait = 0;
        icpu_adr_i    = 32'h0000_0010;
        icpu_cycstb_i = 1'b1;
        tick();
        tick();
        check1("ea err", icpu_err_o, 1'b1);
        check1("ea ack", icpu_ack_o, 1'b0);
        check4("ea tag", icpu_tag_o, 4'hb);
        check32("ea dat", icpu_dat_o, 32'h0);
        icpu_cycstb_i = 1'b0;
        tick();

        // Silent slave: timeout.
        s_mode = 2;
        icpu_adr_i    = 32'h0000_0020;
        icpu_cycstb_i = 1'b1;
        ncyc = 0;
        got  = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (icpu_err_o) got = 1'b1;
            else if (iwb_cyc_o) ncyc++;
        end
        check1("to err seen", got, 1'b1);
        check32("to cyc count", ncyc, 15);
        check4("to tag", icpu_tag_o, 4'hb);
        icpu_cycstb_i = 1'b0;
        tick();

        // Silent slave with one retry mid-way.
        s_mode   = 3;
        s_rty_at = 5;
        rty_done = 1'b0;
        icpu_adr_i    = 32'h0000_0024;
        icpu_cycstb_i = 1'b1;
        ncyc = 0;
        nlow = 0;
        got  = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (icpu_err_o) got = 1'b1;
            else if (iwb_cyc_o) ncyc++;
            else nlow++;
        end
        check1("rty err seen", got, 1'b1);
        check32("rty cyc count", ncyc, 15);
        check32("rty gap", nlow, 1);
        icpu_cycstb_i = 1'b0;
        tick();

        // Cancel mid-fetch, slave acks in cycle 4.
        s_mode = 0;
        s_wait = 3;
        s_dat  = 32'h1234_5678;
        icpu_adr_i    = 32'h0000_0300;
        icpu_cycstb_i = 1'b1;
        npulse = 0;
        tick();
        tick();
        icpu_cycstb_i = 1'b0;
        tick();
        npulse += int'(icpu_ack_o | icpu_err_o);
        check1("cx abort cyc", iwb_cyc_o, 1'b1);
        check32("cx abort adr", iwb_adr_o, 32'h0000_0300);
        icpu_adr_i    = 32'h0000_0400;
        icpu_cycstb_i = 1'b1;
        tick();
        npulse += int'(icpu_ack_o | icpu_err_o);
        tick();
        npulse += int'(icpu_ack_o | icpu_err_o);
        check1("cx idle cyc", iwb_cyc_o, 1'b0);
        check32("cx no pulse", npulse, 0);
        tick();
        check1("cx new cyc", iwb_cyc_o, 1'b1);
        check32("cx new adr", iwb_adr_o, 32'h0000_0400);
        got = 1'b0;
        ncyc = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            ncyc++;
            if (icpu_ack_o) got = 1'b1;
        end
        check1("cx new ack", got, 1'b1);
        check32("cx new lat", ncyc, 4);
        check32("cx new icpu_adr", icpu_adr_o, 32'h0000_0400);
        check32("cx new dat", icpu_dat_o, 32'h1234_5678);
        icpu_cycstb_i = 1'b0;
        tick();

        // Reset during a bus cycle.
        s_mode = 2;
        icpu_adr_i    = 32'h0000_0600;
        icpu_cycstb_i = 1'b1;
        tick();
        tick();
        tick();
        check1("mr cyc before", iwb_cyc_o, 1'b1);
        #2 rst = 1'b0;
        icpu_cycstb_i = 1'b0;
        #1;
        check1("mr cyc", iwb_cyc_o, 1'b0);
        check1("mr stb", iwb_stb_o, 1'b0);
        check1("mr ack", icpu_ack_o, 1'b0);
        check1("mr err", icpu_err_o, 1'b0);
        check32("mr icpu_adr", icpu_adr_o, 32'h0);
        check32("mr iwb_adr", iwb_adr_o, 32'h0);
        check4("mr tag", icpu_tag_o, 4'h0);
        @(posedge clk);
        #3 rst = 1'b1;
        s_mode = 0;
        s_wait = 0;
        s_dat  = 32'hdead_beef;
        icpu_adr_i    = 32'h0000_0700;
        icpu_cycstb_i = 1'b1;
        tick();
        check1("mr post cyc", iwb_cyc_o, 1'b1);
        tick();
        check1("mr post ack", icpu_ack_o, 1'b1);
        check32("mr post dat", icpu_dat_o, 32'hdead_beef);
        check32("mr post adr", icpu_adr_o, 32'h0000_0700);
        icpu_cycstb_i = 1'b0;
        tick();

        // Randomized traffic against the model.
        s_mode = 4;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (icpu_ack_o || icpu_err_o || $urandom_range(0, 19) == 0) begin
                icpu_cycstb_i = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 3) == 0)
                    icpu_adr_i = icpu_adr_i ^ ($urandom & 32'h3);
                else
                    icpu_adr_i = ($urandom & 32'h0000_0ffc) | ($urandom & 32'h3);
            end
        end
        icpu_cycstb_i = 1'b0;
        repeat (20) tick();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/or1200_ifetch_resp.md
# or1200_ifetch_resp

Instruction-fetch responder: the far end of the CPU-side instruction port (icpu_*) that the IF stage consumes. It accepts fetch requests from the PC generator, performs single Wishbone classic reads on the instruction bus, and returns instruction word, acknowledge or error, echoed address and ITAG to the IF stage. It sits between the CPU core and the instruction Wishbone bus when the instruction cache is not built in. It also handles retries, timeouts and cancelled fetches.

## Interface
- TIMEOUT_W, 4: timeout counter width; a fetch is terminated after 2^TIMEOUT_W−1 (15) bus cycles without ack/err.
- clk  in  1  core clock.
- rst  in  1  one clock; reset is asynchronous and active-low.
- icpu_adr_i  in  32  fetch address from PC generator; bits [1:0] ignored.
- icpu_cycstb_i  in  1  fetch request; deassertion cancels an outstanding fetch.
- icpu_dat_o  out  32  fetched instruction; 32'h0 when not acking.
- icpu_ack_o  out  1  one-cycle pulse, instruction valid.
- icpu_err_o  out  1  one-cycle pulse, fetch failed.
- icpu_adr_o  out  32  word address ({adr[31:2],2'b00}) of the returned fetch.
- icpu_tag_o  out  4  4'h1 (ITAG_NI) with ack, 4'hb (ITAG_BE) with err, 4'h0 otherwise.
- iwb_adr_o  out  32  bus address, word aligned.
- iwb_cyc_o, iwb_stb_o  out  1  Wishbone cycle/strobe, always equal.
- iwb_we_o  out  1  constant 0.
- iwb_sel_o  out  4  constant 4'hf.
- iwb_cti_o  out  3  constant 3'b000.
- iwb_dat_i  in  32  read data.
- iwb_ack_i, iwb_err_i, iwb_rty_i  in  1  Wishbone terminations.

## Operation
- FSM states: IDLE, REQ, RETRY, ABORT. All outputs registered.
- IDLE:
  - If icpu_cycstb_i=1, latch {icpu_adr_i[31:2],2'b00} into addr_q, clear timeout counter, go to REQ.
  - iwb_adr_o=addr_q, cyc/stb=1 from the next cycle.
- REQ: cyc/stb=1.
  - Priority: iwb_err_i > iwb_ack_i > iwb_rty_i > timeout.
  - ack: pulse icpu_ack_o, icpu_dat_o=iwb_dat_i, tag 4'h1, icpu_adr_o=addr_q, go to IDLE.
  - err or timeout: pulse icpu_err_o, dat 0, tag 4'hb, icpu_adr_o=addr_q, go to IDLE.
  - rty: go to RETRY; the timeout counter is not cleared.
  - Otherwise increment the counter. Timeout fires in the cycle the counter reaches 2^TIMEOUT_W−1.
- RETRY: cyc/stb=0 for exactly one cycle, then REQ with the same address.
- Cancel: in REQ or RETRY, icpu_cycstb_i=0 or icpu_adr_i[31:2]≠addr_q[31:2] means the fetch is stale.
  - A stale fetch in REQ with no termination that cycle goes to ABORT.
  - A stale fetch in RETRY goes to IDLE and drops cyc.
  - If cancel coincides with ack/err/timeout, the result is discarded: no icpu pulse, go to IDLE. Cancel wins.
- ABORT: cyc/stb held at 1 until ack/err/rty/timeout, then IDLE. No icpu_ack_o/icpu_err_o is generated. A new request is serviced from IDLE.
- Only one outstanding bus cycle at a time. icpu_dat_o/tag/adr_o hold their values only during the pulse cycle; otherwise dat=0, tag=0. adr_o keeps its last value.

## Timing
- Reset values (async, rst=0):
  - State IDLE.
  - cyc/stb 0; iwb_adr_o 0.
  - icpu_ack_o 0, icpu_err_o 0.
  - icpu_dat_o 0, icpu_adr_o 0, icpu_tag_o 4'h0.
  - Counter 0.
- Reset mid-fetch drops cyc immediately and emits no pulse.
- Latency with a zero-wait slave:
  - Request sampled at edge 0; cyc/stb high in cycle 1.
  - iwb_ack_i in cycle 1; icpu_ack_o high in cycle 2.
  - Minimum 2 cycles from request to ack; throughput 1 fetch per 2 cycles.
- Each additional slave wait state adds one cycle.
- icpu_ack_o and icpu_err_o are never high together, and never high for two consecutive cycles for the same fetch.

## Test plan
- Zero-wait read, adr 32'h0000_0104, iwb_dat_i 32'h1500_0000:
  - cyc in cycle 1, iwb_adr_o 32'h0000_0104.
  - Cycle 2: icpu_ack_o=1, dat 32'h1500_0000, tag 4'h1, icpu_adr_o 32'h104.
- Address 32'h0000_0203 with 3 wait states: iwb_adr_o 32'h200; icpu_ack_o 5 cycles after the request.
- iwb_err_i with iwb_ack_i in the same cycle: icpu_err_o=1, icpu_ack_o=0, tag 4'hb, dat 0.
- Slave silent:
  - cyc stays high for 15 cycles, then drops.
  - icpu_err_o pulses with tag 4'hb.
  - One rty mid-way: cyc low 1 cycle, total timeout still 15 REQ cycles.
- Cancel: icpu_cycstb_i drops in cycle 2 of a fetch to 32'h300, ack in cycle 4:
  - No icpu pulse.
  - A new request to 32'h400 issues cyc only after ABORT completes.
- rst asserted while cyc=1: cyc/stb and all icpu outputs go to 0 immediately; after release, a fetch works normally.
